// File: rtl/branch_unit_if.sv
// Decode/fetch-facing signal bundle of branch_unit: instruction and ALU inputs, redirect handshake and status.
interface branch_unit_if #(
  parameter int PC_W    = 12,
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16
);
  logic               en_branch;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    link_pc;
  logic               alu_valid;
  logic [DATA_W-1:0]  alu_result;
  logic               redirect_ready;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               busy;
  logic               is_branch;
  logic               flags_valid;
  logic               ras_underflow;

  modport master (
    output en_branch, instruction, link_pc, alu_valid, alu_result, redirect_ready,
    input  redirect_valid, redirect_pc, busy, is_branch, flags_valid, ras_underflow
  );

  modport slave (
    input  en_branch, instruction, link_pc, alu_valid, alu_result, redirect_ready,
    output redirect_valid, redirect_pc, busy, is_branch, flags_valid, ras_underflow
  );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution unit: registered Z/N flags with forwarding, branch decode and a registered PC redirect.
// Optional macro BRANCH_RAS_EN adds CALL/RET through a circular return-address stack.
module branch_unit #(
  parameter int PC_W      = 12,
  parameter int DATA_W    = 16,
  parameter int INSTR_W   = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  branch_unit_if.slave bus
);
  typedef enum logic {IDLE, REDIRECT} state_e;
  typedef enum logic [1:0] {C_EQZ, C_NEZ, C_NEG, C_ALWAYS} cond_e;

  localparam int TGT_W = INSTR_W - 4;

  state_e          state_q, state_d;
  logic            z_q, n_q, flags_valid_q;
  logic [PC_W-1:0] redirect_pc_q, pc_d;
  logic            load_pc;
  logic [1:0]      op;
  cond_e           cond;
  logic            accept, z_eff, n_eff, fv_eff, cond_true, take_branch;
  logic [PC_W-1:0] target;
  logic            is_call, is_ret, ras_underflow_q;
  logic [PC_W-1:0] ret_pc;

  assign op     = bus.instruction[1:0];
  assign cond   = cond_e'(bus.instruction[3:2]);
  assign accept = bus.en_branch & (state_q == IDLE);

  // An ALU result arriving in the same cycle as the branch overrides the registered flags.
  assign fv_eff = flags_valid_q | bus.alu_valid;
  assign z_eff  = bus.alu_valid ? (bus.alu_result == '0) : z_q;
  assign n_eff  = bus.alu_valid ? bus.alu_result[DATA_W-1] : n_q;

  if (TGT_W >= PC_W) begin : g_trunc
    assign target = bus.instruction[PC_W+3:4];
  end else begin : g_zext
    assign target = {{(PC_W-TGT_W){1'b0}}, bus.instruction[INSTR_W-1:4]};
  end

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      C_EQZ:    cond_true = fv_eff & z_eff;
      C_NEZ:    cond_true = fv_eff & ~z_eff;
      C_NEG:    cond_true = fv_eff & n_eff;
      C_ALWAYS: cond_true = 1'b1;
    endcase
  end

  assign take_branch = (op == 2'd2) & cond_true;

`ifdef BRANCH_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ras_push, ras_pop, ras_empty;

  assign is_call   = (op == 2'd3) & (bus.instruction[3:2] == 2'd0);
  assign is_ret    = (op == 2'd3) & (bus.instruction[3:2] == 2'd1);
  assign ras_push  = accept & is_call;
  assign ras_pop   = accept & is_ret;
  assign ras_empty = (cnt_q == '0);
  // ptr_q names the next free slot; wrapping it overwrites the oldest entry when full.
  assign ret_pc    = ras_empty ? '0 : ras_mem[ptr_q - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q           <= '0;
      cnt_q           <= '0;
      ras_underflow_q <= 1'b0;
    end else begin
      ras_underflow_q <= ras_pop & ras_empty;
      if (ras_push) begin
        ptr_q <= ptr_q + PTR_W'(1);
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + CNT_W'(1);
      end else if (ras_pop && !ras_empty) begin
        ptr_q <= ptr_q - PTR_W'(1);
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: stack storage is deliberately not reset; count alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ptr_q] <= bus.link_pc;
  end
`else
  logic unused_ras;

  assign is_call         = 1'b0;
  assign is_ret          = 1'b0;
  assign ret_pc          = '0;
  assign ras_underflow_q = 1'b0;
  assign unused_ras      = ^{bus.link_pc, (RAS_DEPTH > 1)};
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load_pc = 1'b0;
    pc_d    = target;
    unique case (state_q)
      IDLE: begin
        if (accept && (take_branch || is_call || is_ret)) begin
          state_d = REDIRECT;
          load_pc = 1'b1;
          pc_d    = is_ret ? ret_pc : target;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) state_d = IDLE;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      z_q           <= 1'b0;
      n_q           <= 1'b0;
      flags_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_pc) redirect_pc_q <= pc_d;
      if (bus.alu_valid) begin
        z_q           <= (bus.alu_result == '0);
        n_q           <= bus.alu_result[DATA_W-1];
        flags_valid_q <= 1'b1;
      end
    end
  end

  assign bus.redirect_valid = (state_q == REDIRECT);
  assign bus.busy           = (state_q == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.is_branch      = (op == 2'd2);
  assign bus.flags_valid    = flags_valid_q;
  assign bus.ras_underflow  = ras_underflow_q;
endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios followed by randomized traffic against a reference model.
module tb_branch_unit;
  localparam int PC_W      = 12;
  localparam int DATA_W    = 16;
  localparam int INSTR_W   = 16;
  localparam int RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)) bus ();

  branch_unit #(
    .PC_W(PC_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a pending redirect, its PC, the flags and the stack as a queue.
  bit              m_pend, m_z, m_n, m_fv, m_uf;
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_ras [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [1:0] op, input logic [1:0] cond,
                                            input logic [PC_W-1:0] tgt);
    return {tgt, cond, op};
  endfunction

  task automatic drive(input bit en, input logic [INSTR_W-1:0] instr, input logic [PC_W-1:0] link,
                       input bit av, input logic [DATA_W-1:0] ar, input bit rdy);
    bus.en_branch      = en;
    bus.instruction    = instr;
    bus.link_pc        = link;
    bus.alu_valid      = av;
    bus.alu_result     = ar;
    bus.redirect_ready = rdy;
  endtask

  task automatic model_edge();
    bit              fz, fn, fv, take;
    logic [PC_W-1:0] npc;
    logic [1:0]      op, cond;
    if (rst) begin
      m_pend = 0; m_pc = '0; m_z = 0; m_n = 0; m_fv = 0; m_uf = 0;
      m_ras.delete();
      return;
    end
    m_uf = 0;
    op   = bus.instruction[1:0];
    cond = bus.instruction[3:2];
    fv   = m_fv || bus.alu_valid;
    fz   = bus.alu_valid ? (bus.alu_result == 0) : m_z;
    fn   = bus.alu_valid ? bus.alu_result[DATA_W-1] : m_n;
    if (m_pend) begin
      if (bus.redirect_ready) m_pend = 0;
    end else if (bus.en_branch) begin
      take = 0;
      npc  = bus.instruction[INSTR_W-1:4];
      if (op == 2) begin
        case (cond)
          0: take = fv && fz;
          1: take = fv && !fz;
          2: take = fv && fn;
          default: take = 1;
        endcase
      end
`ifdef BRANCH_RAS_EN
      else if (op == 3 && cond == 0) begin
        take = 1;
        m_ras.push_back(bus.link_pc);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (op == 3 && cond == 1) begin
        take = 1;
        if (m_ras.size() == 0) begin
          npc  = '0;
          m_uf = 1;
        end else begin
          npc = m_ras.pop_back();
        end
      end
`endif
      if (take) begin
        m_pend = 1;
        m_pc   = npc;
      end
    end
    if (bus.alu_valid) begin
      m_z  = (bus.alu_result == 0);
      m_n  = bus.alu_result[DATA_W-1];
      m_fv = 1;
    end
  endtask

  // One clock: combinational outputs checked mid-cycle, registered outputs just after the edge.
  task automatic tick();
    @(negedge clk);
    check("busy", bus.busy, m_pend);
    check("is_branch", bus.is_branch, bus.instruction[1:0] == 2'd2);
    @(posedge clk);
    model_edge();
    #1;
    check("redirect_valid", bus.redirect_valid, m_pend);
    check("redirect_pc", bus.redirect_pc, m_pc);
    check("flags_valid", bus.flags_valid, m_fv);
    check("ras_underflow", bus.ras_underflow, m_uf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PC_W-1:0] ret_exp [5];
    bit              en, av, rdy;
    logic [1:0]      op, cond;
    logic [DATA_W-1:0] ar;

    rst = 1'b1;
    drive(0, '0, '0, 0, '0, 0);
    tick();
    tick();
    check("rst_redirect_valid", bus.redirect_valid, 0);
    check("rst_redirect_pc", bus.redirect_pc, 0);
    check("rst_flags_valid", bus.flags_valid, 0);
    rst = 1'b0;

    // ALU writes zero, then EQZ branch on registered Z.
    drive(0, '0, '0, 1, 16'h0000, 0);
    tick();
    drive(1, mk(2, 0, 12'h123), '0, 0, '0, 0);
    tick();
    check("eqz_taken_valid", bus.redirect_valid, 1);
    check("eqz_taken_pc", bus.redirect_pc, 12'h123);
    drive(0, '0, '0, 0, '0, 1);
    tick();
    check("eqz_release", bus.redirect_valid, 0);

    // Forwarded non-zero result beats the stale Z=1.
    drive(1, mk(2, 0, 12'h055), '0, 1, 16'h0005, 0);
    tick();
    check("fwd_not_taken", bus.redirect_valid, 0);

    // ALWAYS branch stalled by fetch; a second branch must be ignored.
    drive(1, mk(2, 3, 12'h0AA), '0, 0, '0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(2, 3, 12'h0BB), '0, 0, '0, 0);
      tick();
      check("stall_pc", bus.redirect_pc, 12'h0AA);
      check("stall_busy", bus.busy, 1);
    end
    drive(0, '0, '0, 0, '0, 1);
    tick();
    check("stall_release", bus.redirect_valid, 0);
    check("stall_pc_kept", bus.redirect_pc, 12'h0AA);

    // Fresh reset: NEG without flags is not taken; ALWAYS to the top address is.
    rst = 1'b1;
    drive(0, '0, '0, 0, '0, 0);
    tick();
    rst = 1'b0;
    drive(1, mk(2, 2, 12'h001), '0, 0, '0, 0);
    tick();
    check("neg_noflags", bus.redirect_valid, 0);
    drive(1, mk(2, 3, 12'hFFF), '0, 1, 16'h8000, 0);
    tick();
    check("always_fff", bus.redirect_pc, 12'hFFF);
    check("always_fff_flags", bus.flags_valid, 1);

    // Reset while a redirect is pending.
    rst = 1'b1;
    drive(0, '0, '0, 0, '0, 0);
    tick();
    check("rst_mid_valid", bus.redirect_valid, 0);
    check("rst_mid_flags", bus.flags_valid, 0);
    rst = 1'b0;

`ifdef BRANCH_RAS_EN
    for (int i = 1; i <= 5; i++) begin
      drive(1, mk(3, 0, PC_W'(12'h100 + i)), PC_W'(i), 0, '0, 1);
      tick();
      check("call_pc", bus.redirect_pc, 12'h100 + i);
      drive(0, '0, '0, 0, '0, 1);
      tick();
    end
    ret_exp[0] = 12'd5; ret_exp[1] = 12'd4; ret_exp[2] = 12'd3; ret_exp[3] = 12'd2; ret_exp[4] = 12'd0;
    for (int i = 0; i < 5; i++) begin
      drive(1, mk(3, 1, 12'h7E7), '0, 0, '0, 1);
      tick();
      check("ret_pc", bus.redirect_pc, ret_exp[i]);
      check("ret_underflow", bus.ras_underflow, (i == 4) ? 1 : 0);
      drive(0, '0, '0, 0, '0, 1);
      tick();
      check("ret_underflow_drop", bus.ras_underflow, 0);
    end
`else
    drive(1, mk(3, 0, 12'h321), 12'h010, 0, '0, 0);
    tick();
    check("op3_nonbranch", bus.redirect_valid, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      en   = ($urandom_range(0, 9) < 7);
      op   = 2'($urandom_range(0, 3));
      cond = 2'($urandom_range(0, 3));
      av   = $urandom_range(0, 1) == 1;
      ar   = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
      rdy  = $urandom_range(0, 1) == 1;
      rst  = ($urandom_range(0, 49) == 0);
      drive(en, mk(op, cond, PC_W'($urandom)), PC_W'($urandom), av, ar, rdy);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
